// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch-in-ID, mult/div freeze.
// Optional HAZARD_STATS_EN adds stall_cycles/flush_count counters.
module hazard_sequencer #(
  parameter int MAX_STALL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_is_store,
  input  logic       ID_is_branch,
  input  logic       ID_branch_taken,
  input  logic       ID_jump,
  input  logic [4:0] ID_EX_dest,
  input  logic       ID_EX_Reg_Write,
  input  logic       ID_EX_Mem_Read,
  input  logic [4:0] EX_MEM_dest,
  input  logic       EX_MEM_Reg_Write,
  input  logic       ID_EX_is_md,
  input  logic       md_done,
  output logic       md_go,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       ID_EX_Write,
  output logic       EX_MEM_Bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    MD_BUSY
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       ex_a, ex_b;
  logic       mem_a, mem_b;
  logic       md_wait;
  logic [1:0] need;
  logic [1:0] need_c;

  assign ex_a  = (ID_EX_dest != 5'd0) && ID_uses_rs
              && (ID_EX_dest == rs);
  assign ex_b  = (ID_EX_dest != 5'd0) && ID_uses_rt
              && (ID_EX_dest == rt);
  assign mem_a = (EX_MEM_dest != 5'd0) && ID_uses_rs
              && (EX_MEM_dest == rs);
  assign mem_b = (EX_MEM_dest != 5'd0) && ID_uses_rt
              && (EX_MEM_dest == rt);

  assign md_wait = ID_EX_is_md && !md_done;

  // Strongest requirement wins; later assignments dominate.
  always_comb begin
    need_c = 2'd0;
    if (ID_EX_Mem_Read && (ex_a || (ex_b && !ID_is_store)))
      need_c = 2'd1;
    if (ID_is_branch && EX_MEM_Reg_Write && (mem_a || mem_b))
      need_c = 2'd1;
    if (ID_is_branch && ID_EX_Reg_Write && (ex_a || ex_b))
      need_c = 2'd2;
  end

  assign need = (need_c > 2'(MAX_STALL)) ? 2'(MAX_STALL) : need_c;

  always_comb begin
    md_go         = 1'b0;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Write   = 1'b1;
    EX_MEM_Bubble = 1'b0;
    if (rst) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (md_wait) begin
            md_go         = 1'b1;
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
          end else if (need != 2'd0) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (ID_branch_taken || ID_jump) begin
            IF_ID_Flush = 1'b1;
          end
        end
        STALL: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
        MD_BUSY: begin
          if (!md_done) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (md_wait) begin
            state <= MD_BUSY;
          end else if (need != 2'd0) begin
            cnt   <= need - 2'd1;
            state <= (need > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          if (cnt != 2'd0)
            cnt <= cnt - 2'd1;
          if (cnt <= 2'd1)
            state <= RUN;
        end
        MD_BUSY: begin
          if (md_done)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!PC_Write && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (IF_ID_Flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed plan steps then random cycles
// against a cycle-level behavioural model.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt;
  logic       ID_uses_rs, ID_uses_rt;
  logic       ID_is_store, ID_is_branch;
  logic       ID_branch_taken, ID_jump;
  logic [4:0] ID_EX_dest;
  logic       ID_EX_Reg_Write, ID_EX_Mem_Read;
  logic [4:0] EX_MEM_dest;
  logic       EX_MEM_Reg_Write;
  logic       ID_EX_is_md, md_done;
  logic       md_go, PC_Write, IF_ID_Write, IF_ID_Flush;
  logic       ID_EX_Bubble, ID_EX_Write, EX_MEM_Bubble;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  // model state: stall cycles still owed, waiting on mult/div
  int m_stall_left = 0;
  bit m_md_wait    = 1'b0;
  int m_stalls     = 0;
  int m_flushes    = 0;

  hazard_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .rs               (rs),
    .rt               (rt),
    .ID_uses_rs       (ID_uses_rs),
    .ID_uses_rt       (ID_uses_rt),
    .ID_is_store      (ID_is_store),
    .ID_is_branch     (ID_is_branch),
    .ID_branch_taken  (ID_branch_taken),
    .ID_jump          (ID_jump),
    .ID_EX_dest       (ID_EX_dest),
    .ID_EX_Reg_Write  (ID_EX_Reg_Write),
    .ID_EX_Mem_Read   (ID_EX_Mem_Read),
    .EX_MEM_dest      (EX_MEM_dest),
    .EX_MEM_Reg_Write (EX_MEM_Reg_Write),
    .ID_EX_is_md      (ID_EX_is_md),
    .md_done          (md_done),
    .md_go            (md_go),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .ID_EX_Write      (ID_EX_Write),
    .EX_MEM_Bubble    (EX_MEM_Bubble)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // {go, pc, ifw, flush, bubble, idw, exb}
  localparam logic [6:0] O_NORM  = 7'b0110010;
  localparam logic [6:0] O_FLUSH = 7'b0111010;
  localparam logic [6:0] O_STALL = 7'b0000110;
  localparam logic [6:0] O_FRZ   = 7'b0000001;
  localparam logic [6:0] O_GO    = 7'b1000001;
  localparam logic [6:0] O_RST   = 7'b0001111;

  function automatic bool_hit(input logic [4:0] d,
                              input logic [4:0] r,
                              input logic use_r);
    return (d != 0) && use_r && (d == r);
  endfunction

  function automatic int needed();
    int n = 0;
    bit ea, eb, ma, mb;
    ea = bool_hit(ID_EX_dest, rs, ID_uses_rs);
    eb = bool_hit(ID_EX_dest, rt, ID_uses_rt);
    ma = bool_hit(EX_MEM_dest, rs, ID_uses_rs);
    mb = bool_hit(EX_MEM_dest, rt, ID_uses_rt);
    if (ID_EX_Mem_Read && (ea || (eb && !ID_is_store)))
      n = 1;
    if (ID_is_branch && EX_MEM_Reg_Write && (ma || mb))
      n = (n > 1) ? n : 1;
    if (ID_is_branch && ID_EX_Reg_Write && (ea || eb))
      n = 2;
    return n;
  endfunction

  task automatic clr();
    rs = 0; rt = 0;
    ID_uses_rs = 0; ID_uses_rt = 0;
    ID_is_store = 0; ID_is_branch = 0;
    ID_branch_taken = 0; ID_jump = 0;
    ID_EX_dest = 0; ID_EX_Reg_Write = 0;
    ID_EX_Mem_Read = 0;
    EX_MEM_dest = 0; EX_MEM_Reg_Write = 0;
    ID_EX_is_md = 0; md_done = 0;
  endtask

  // one cycle: inputs already set at negedge
  task automatic cyc(input string tag);
    logic [6:0] exp, obs;
    int nsl;
    bit nmd;
    int n;
    #1;
    nsl = m_stall_left;
    nmd = m_md_wait;
    if (rst) begin
      exp = O_RST;
      nsl = 0;
      nmd = 0;
      m_stalls = 0;
      m_flushes = 0;
    end else if (m_md_wait) begin
      exp = md_done ? O_NORM : O_FRZ;
      nmd = !md_done;
    end else if (m_stall_left > 0) begin
      exp = O_STALL;
      nsl = m_stall_left - 1;
    end else begin
      n = needed();
      if (ID_EX_is_md && !md_done) begin
        exp = O_GO;
        nmd = 1;
      end else if (n > 0) begin
        exp = O_STALL;
        nsl = n - 1;
      end else if (ID_branch_taken || ID_jump) begin
        exp = O_FLUSH;
      end else begin
        exp = O_NORM;
      end
    end
    obs = {md_go, PC_Write, IF_ID_Write, IF_ID_Flush,
           ID_EX_Bubble, ID_EX_Write, EX_MEM_Bubble};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outs obs=%b exp=%b", tag, obs, exp);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    assert (stall_cycles === 16'(m_stalls)
            && flush_count === 16'(m_flushes)) else begin
      errors++;
      $error("FAIL %s stats obs=%0d/%0d exp=%0d/%0d", tag,
             stall_cycles, flush_count, m_stalls, m_flushes);
    end
`endif
    @(posedge clk);
    if (!rst) begin
      if (exp[5] == 1'b0 && m_stalls < 16'hFFFF)
        m_stalls++;
      if (exp[3] && m_flushes < 16'hFFFF)
        m_flushes++;
    end
    m_stall_left = nsl;
    m_md_wait = nmd;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    cyc("reset");
    rst = 1'b0;
    cyc("idle");

    // load-use on rs
    ID_EX_Mem_Read = 1; ID_EX_Reg_Write = 1;
    ID_EX_dest = 2; rs = 2; ID_uses_rs = 1;
    cyc("lu_stall");
    ID_EX_Mem_Read = 0; ID_EX_dest = 0;
    cyc("lu_after");

    // store exemption
    clr();
    ID_EX_Mem_Read = 1; ID_EX_Reg_Write = 1;
    ID_EX_dest = 2;
    ID_is_store = 1; ID_uses_rs = 1; ID_uses_rt = 1;
    rt = 2; rs = 5;
    cyc("sw_exempt");
    rs = 2;
    cyc("sw_rs_stall");
    clr();
    cyc("sw_after");

    // branch two-cycle stall then taken flush
    ID_is_branch = 1; ID_uses_rs = 1; rs = 3;
    ID_EX_Reg_Write = 1; ID_EX_dest = 3;
    cyc("br_stall0");
    cyc("br_stall1");
    ID_EX_Reg_Write = 0; ID_EX_dest = 0;
    ID_branch_taken = 1;
    cyc("br_flush");
    clr();
    cyc("br_after");

    // mult/div freeze, done after 4 cycles
    ID_EX_is_md = 1;
    for (int i = 0; i < 4; i++) cyc("md_frz");
    md_done = 1;
    cyc("md_done");
    clr();
    cyc("md_after");

    // zero-latency md completion
    ID_EX_is_md = 1; md_done = 1;
    cyc("md_zero");
    clr();

    // md with concurrent load-use
    ID_EX_is_md = 1; ID_EX_Mem_Read = 1;
    ID_EX_dest = 2; rs = 2; ID_uses_rs = 1;
    cyc("md_lu_frz0");
    cyc("md_lu_frz1");
    md_done = 1;
    cyc("md_lu_exit");
    ID_EX_is_md = 0; md_done = 0;
    cyc("md_lu_stall");
    clr();
    cyc("md_lu_after");

    // reset during STALL
    ID_is_branch = 1; ID_uses_rt = 1; rt = 4;
    ID_EX_Reg_Write = 1; ID_EX_dest = 4;
    cyc("rst_pre");
    rst = 1;
    cyc("rst_mid");
    rst = 0;
    clr();
    cyc("rst_post");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      ID_uses_rs = 1'($urandom);
      ID_uses_rt = 1'($urandom);
      ID_is_store = 1'($urandom);
      ID_is_branch = 1'($urandom);
      ID_branch_taken = 1'($urandom);
      ID_jump = ($urandom_range(0, 3) == 0);
      ID_EX_dest = 5'($urandom_range(0, 3));
      ID_EX_Reg_Write = 1'($urandom);
      ID_EX_Mem_Read = 1'($urandom);
      EX_MEM_dest = 5'($urandom_range(0, 3));
      EX_MEM_Reg_Write = 1'($urandom);
      ID_EX_is_md = ($urandom_range(0, 5) == 0);
      md_done = ($urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
